pool_rmw_bram: RTL

Parametrised on-chip pooling buffer that succeeds the plain single-write/single-read pooling BRAM. It adds a per-write accumulate mode: overwrite, lane-wise max, or lane-wise saturating add. This lets max- and sum-pooling windows be reduced in place as feature-map rows stream in. It sits between the conv/activation output stream and the pooling/next-layer reader, with an independent registered read port.

---
 rtl/pool_bram_pkg.sv | 12 +
 rtl/pool_lane_alu.sv | 25 ++
 rtl/pool_rmw_bram.sv | 73 +++++++
 3 files changed

// File: rtl/pool_bram_pkg.sv
// pool_bram_pkg: shared accumulate-mode codes and lane saturation bounds for the pooling RMW buffer
package pool_bram_pkg;
  localparam logic [1:0] MODE_WR  = 2'd0;
  localparam logic [1:0] MODE_MAX = 2'd1;
  localparam logic [1:0] MODE_ADD = 2'd2;
  function automatic longint sat_hi(input int w, input bit sgn);
    return sgn ? (longint'(1) << (w - 1)) - longint'(1) : (longint'(1) << w) - longint'(1);
  endfunction
  function automatic longint sat_lo(input int w, input bit sgn);
    return sgn ? -(longint'(1) << (w - 1)) : longint'(0);
  endfunction
endpackage

// File: rtl/pool_lane_alu.sv
// pool_lane_alu: one lane of overwrite/max/saturating-add; ports mode, old (stored lane), opnd (incoming lane), res
module pool_lane_alu
  import pool_bram_pkg::*;
#(
  parameter int W = 8,
  parameter bit S = 1'b1
) (
  input  logic [1:0]   mode,
  input  logic [W-1:0] old,
  input  logic [W-1:0] opnd,
  output logic [W-1:0] res
);
  localparam logic signed [W+1:0] HI = (W+2)'(sat_hi(W, S));
  localparam logic signed [W+1:0] LO = (W+2)'(sat_lo(W, S));
  // Two guard bits let one signed compare/add serve both signed and unsigned lanes.
  logic signed [W+1:0] a, b, sum;
  always_comb begin
    a   = S ? {{2{old[W-1]}}, old} : {2'b00, old};
    b   = S ? {{2{opnd[W-1]}}, opnd} : {2'b00, opnd};
    sum = a + b;
    res = mode == MODE_MAX ? (a > b ? old : opnd) :
          mode == MODE_ADD ? (sum > HI ? HI[W-1:0] : sum < LO ? LO[W-1:0] : sum[W-1:0]) :
          opnd;
  end
endmodule

// File: rtl/pool_rmw_bram.sv
// pool_rmw_bram: pooling buffer with a 2-stage read-modify-write port (overwrite/max/add-sat) and a registered read port.
// Ports: clk, rst (sync, active high); wr_en/wr_mode/wr_addr/wr_data issue one RMW op per cycle;
// rd_en/rd_addr request a read returned on rd_data/rd_valid one cycle later.
// Define POOL_RMW_RD_BYPASS_EN to make the read port return a same-edge committed result (write-first).
module pool_rmw_bram
  import pool_bram_pkg::*;
#(
  parameter int ELEM_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int DEPTH      = 100352,
  parameter int ADDR_WIDTH = 17,
  parameter int SIGNED     = 1,
  localparam int DATA_WIDTH = ELEM_WIDTH * LANES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [1:0]            wr_mode,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH + 1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  s1_valid, s2_valid, rd_hit;
  logic [1:0]            s1_mode;
  logic [ADDR_WIDTH-1:0] s1_addr, s2_addr;
  logic [DATA_WIDTH-1:0] s1_data, ram_q, s2_result, old, result;
  // The internal read is read-first, so the op committed last edge must be forwarded.
  assign old = s2_valid && s2_addr == s1_addr ? s2_result : ram_q;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pool_lane_alu #(.W(ELEM_WIDTH), .S(SIGNED != 0)) u_alu (
      .mode(s1_mode),
      .old (old[l*ELEM_WIDTH +: ELEM_WIDTH]),
      .opnd(s1_data[l*ELEM_WIDTH +: ELEM_WIDTH]),
      .res (result[l*ELEM_WIDTH +: ELEM_WIDTH])
    );
  end
`ifdef POOL_RMW_RD_BYPASS_EN
  assign rd_hit = s1_valid && s1_addr == rd_addr;
`else
  assign rd_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst && s1_valid) mem[s1_addr] <= result;
    if (wr_en) ram_q <= mem[wr_addr];
  end
  always_ff @(posedge clk) begin
    if (wr_en) begin
      s1_mode <= wr_mode;
      s1_addr <= wr_addr;
      s1_data <= wr_data;
    end
    s2_addr   <= s1_addr;
    s2_result <= result;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      s1_valid <= wr_en && {1'b0, wr_addr} < LIM;
      s2_valid <= s1_valid;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= {1'b0, rd_addr} >= LIM ? '0 : rd_hit ? result : mem[rd_addr];
    end
  end
endmodule
